demux64_scatter: RTL and testbench
==================================

Name: demux64_scatter

Overview:
- Pipelined 1-to-64 write distributor for 32-bit words.
- Each accepted word is steered by a 6-bit slot index into one of 64 holding registers, tracked by a per-slot valid mask.
- Pairs with the 64:1 select tree in the first SZ stages: the select tree gathers one word out of 64; this block scatters a stream of words back into 64 lanes and flags when a full set has arrived.
- Decode is staged two index bits per cycle, so its latency matches the 3-cycle select tree.

Parameters:
- WIDTH, 32, data word width.
- NSLOT, 64, number of slots; fixed at 64 (index width 6, three 2-bit decode stages).
- CNTW, 8, width of the completed-set counter.

Ports:
- clock  input  1  single clock, all state on rising edge.
- aclr  input  1  asynchronous active-high reset.
- in_valid  input  1  word on datax/sel is accepted this cycle; there is no backpressure.
- datax  input  WIDTH  word to store.
- sel  input  6  destination slot index, 0..63.
- clear  input  1  synchronous; empties slot_valid and clears ovr_err.
- slots_flat  output  NSLOT*WIDTH  holding registers; slot k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH].
- slot_valid  output  NSLOT  bit k set when slot k has been written since the last empty.
- frame_done  output  1  one-cycle pulse when a full set of 64 slots completes.
- frame_count  output  CNTW  number of completed sets, wraps modulo 2^CNTW.
- ovr_err  output  1  sticky flag: a write landed on an already-valid slot.

Behaviour:
- Reset (aclr=1, asynchronous):
  - slots_flat, slot_valid, frame_count = 0.
  - frame_done, ovr_err = 0.
  - All pipeline valid bits = 0, so in-flight words are discarded.
- Pipeline:
  - S1 registers {valid, datax, sel} and decodes sel[5:4] to a 4-bit group enable.
  - S2 refines with sel[3:2] to a 16-bit enable.
  - S3 refines with sel[1:0] to a 64-bit one-hot write enable.
  - At the S3 edge the word is written: a word accepted at edge t lands in slots_flat and slot_valid at edge t+3.
  - Full throughput: one word per cycle. Back-to-back writes to the same slot land in order; the last one wins.
- Landing write to slot k:
  - slots_flat[k] <= word and slot_valid[k] <= 1.
  - If slot_valid[k] was already 1 and clear is not asserted this cycle, ovr_err <= 1.
- Completion:
  - Applies when the landing write would make all 64 slot_valid bits 1.
  - On that edge slot_valid <= 0, frame_done <= 1 for exactly one cycle, and frame_count <= frame_count+1, wrapping 2^CNTW-1 to 0.
  - slots_flat is retained, so the completed set stays readable until it is overwritten.
- clear:
  - slot_valid <= 0 and ovr_err <= 0.
  - slots_flat is unchanged. In-flight pipeline words are not flushed.
- clear and a landing write on the same edge: clear applies first, then the write, so slot_valid ends with only bit k set, and no ovr_err is raised.
- Completion with clear on the same edge: not possible, because clear empties the mask before the write is evaluated.
- frame_done is 0 in every cycle other than the one following a completion edge.
- in_valid=0 inserts a bubble; no state changes at that bubble's landing edge.
- aclr asserted mid-stream drops all in-flight words. The first write after release lands 3 cycles after its acceptance edge.

Decomposition:
- Shared package sz_mux_pkg holds:
  - constants NSLOT=64, SELW=6, DEC_STAGES=3;
  - a slot-index typedef (6-bit);
  - a data-word typedef (32-bit).
  The same constants size the 64:1 select tree.
- One natural sub-module, dec2_stage: a registered stage that takes a valid bit, word, remaining index bits and an N-bit enable, and produces a 4N-bit enable refined by 2 index bits. It is instantiated three times with N=1, 4, 16.
- The slot register bank, valid mask, completion logic and counters live in the top module.

Test Plan:
- Reset then idle: after aclr pulse, hold in_valid=0 for 10 cycles -> all outputs 0 throughout.
- Latency: one write, sel=37, datax=32'hDEADBEEF, at edge t -> slot 37 = DEADBEEF and slot_valid=1<<37 at edge t+3, not before; other slots 0.
- Full set: 64 back-to-back writes, sel=0..63, datax=sel+32'h100 -> one frame_done pulse one cycle after the 64th landing; frame_count=1; slot_valid=0; slot 63=32'h13F; ovr_err=0.
- Overwrite: write sel=5 twice (data 1 then 2) -> slot 5=2, ovr_err=1 and it stays 1; then clear -> ovr_err=0, slot_valid=0, slot 5 still 2.
- Clear collision: assert clear on the same edge that a write to sel=9 lands while slot_valid=0x0F -> slot_valid=1<<9 afterwards, ovr_err=0.
- Wrap and reset mid-stream: complete 256 sets -> frame_count wraps to 0 with 256 frame_done pulses; then accept sel=1, 2, 3 and assert aclr one cycle later -> nothing lands after release, all outputs 0.

Source files
------------

// File: rtl/sz_mux_pkg.sv
// Shared constants and types for the 64-lane select/scatter pair.
// The 64:1 select tree gathers one word out of NSLOT lanes. The demux64_scatter
// block distributes a stream of words back into those lanes. Both blocks take
// their sizing from this package.
//   NSLOT      : number of lanes (fixed at 64)
//   SELW       : lane index width
//   DEC_STAGES : number of 2-bit decode/select stages (SELW / 2)
package sz_mux_pkg;

  localparam int NSLOT      = 64;
  localparam int SELW       = 6;
  localparam int DEC_STAGES = 3;

  typedef logic [SELW-1:0] slot_idx_t;
  typedef logic [31:0]     word_t;

endpackage

// File: rtl/dec2_stage.sv
// One registered stage of the staged slot decoder.
// The stage takes an N-bit group enable and refines it with the two index bits
// at position LO. The result is a 4N-bit enable. The valid bit, data word and
// full index travel alongside, so that every stage sees the same transaction.
// Ports:
//   clock, aclr : clock, asynchronous active-high reset
//   valid       : incoming transaction valid
//   data        : incoming word
//   idx         : full slot index (only bits [LO+1:LO] are decoded here)
//   en          : incoming N-bit group enable
//   valid_q     : registered valid
//   data_q      : registered word
//   idx_q       : registered index
//   en_q        : registered 4N-bit refined enable
module dec2_stage
  import sz_mux_pkg::*;
#(
  parameter int N     = 1,
  parameter int WIDTH = 32,
  parameter int LO    = 4
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic             valid,
  input  logic [WIDTH-1:0] data,
  input  slot_idx_t        idx,
  input  logic [N-1:0]     en,
  output logic             valid_q,
  output logic [WIDTH-1:0] data_q,
  output slot_idx_t        idx_q,
  output logic [4*N-1:0]   en_q
);

  logic [1:0]     pair;
  logic [4*N-1:0] en_nxt;

  assign pair = idx[LO +: 2];

  // Group g of the incoming enable expands to sub-lanes 4g..4g+3.
  // Only the sub-lane that matches this stage's index pair stays enabled.
  always_comb begin
    en_nxt = '0;
    for (int g = 0; g < N; g++) begin
      for (int d = 0; d < 4; d++) begin
        en_nxt[4*g + d] = en[g] && (pair == 2'(d));
      end
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      en_q    <= '0;
    end else begin
      valid_q <= valid;
      data_q  <= data;
      idx_q   <= idx;
      en_q    <= en_nxt;
    end
  end

endmodule

// File: rtl/demux64_scatter.sv
// Pipelined 1-to-64 write distributor.
// An accepted word is steered by its 6-bit slot index into one of 64 holding
// registers. The slot index is decoded two bits per cycle across three
// dec2_stage instances. The word is written one edge after the last stage, so
// a word accepted at edge t lands at edge t+3. A per-slot valid mask tracks
// which slots have been filled. When the mask fills, the set is counted and
// frame_done pulses for one cycle.
// Ports:
//   clock       : clock, all state on rising edge
//   aclr        : asynchronous active-high reset, discards in-flight words
//   in_valid    : accept datax/sel this cycle
//   datax       : word to store
//   sel         : destination slot 0..63
//   clear       : synchronous; empties slot_valid and clears ovr_err
//   slots_flat  : holding registers; slot k at [k*WIDTH +: WIDTH]
//   slot_valid  : bit k set when slot k was written since the last empty
//   frame_done  : one-cycle pulse after a full set completes
//   frame_count : completed sets, modulo 2^CNTW
//   ovr_err     : sticky; a write landed on an already-valid slot
//
// Handshake: in_valid is a qualifier only. A word presented with in_valid=1
// on a rising edge is always accepted, and there is no ready/backpressure.
// A cycle with in_valid=0 is a bubble, and no state changes at its landing edge.
module demux64_scatter
  import sz_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NSLOT = 64,
  parameter int CNTW  = 8
) (
  input  logic                   clock,
  input  logic                   aclr,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       datax,
  input  slot_idx_t              sel,
  input  logic                   clear,
  output logic [NSLOT*WIDTH-1:0] slots_flat,
  output logic [NSLOT-1:0]       slot_valid,
  output logic                   frame_done,
  output logic [CNTW-1:0]        frame_count,
  output logic                   ovr_err
);

  // Pipeline stage signals.
  logic             s1_valid, s2_valid, s3_valid;
  logic [WIDTH-1:0] s1_data, s2_data, s3_data;
  slot_idx_t        s1_idx, s2_idx, s3_idx;
  logic [3:0]       s1_en;
  logic [15:0]      s2_en;
  logic [NSLOT-1:0] s3_en;

  // Decode sel[5:4]: one group enable becomes 4.
  dec2_stage #(.N(1), .WIDTH(WIDTH), .LO(4)) u_dec1 (
    .clock   (clock),
    .aclr    (aclr),
    .valid   (in_valid),
    .data    (datax),
    .idx     (sel),
    .en      (1'b1),
    .valid_q (s1_valid),
    .data_q  (s1_data),
    .idx_q   (s1_idx),
    .en_q    (s1_en)
  );

  // Decode sel[3:2]: 4 group enables become 16.
  dec2_stage #(.N(4), .WIDTH(WIDTH), .LO(2)) u_dec2 (
    .clock   (clock),
    .aclr    (aclr),
    .valid   (s1_valid),
    .data    (s1_data),
    .idx     (s1_idx),
    .en      (s1_en),
    .valid_q (s2_valid),
    .data_q  (s2_data),
    .idx_q   (s2_idx),
    .en_q    (s2_en)
  );

  // Decode sel[1:0]: 16 group enables become the 64-bit one-hot.
  dec2_stage #(.N(16), .WIDTH(WIDTH), .LO(0)) u_dec3 (
    .clock   (clock),
    .aclr    (aclr),
    .valid   (s2_valid),
    .data    (s2_data),
    .idx     (s2_idx),
    .en      (s2_en),
    .valid_q (s3_valid),
    .data_q  (s3_data),
    .idx_q   (s3_idx),
    .en_q    (s3_en)
  );

  logic [NSLOT-1:0][WIDTH-1:0] slots_q;
  logic [NSLOT-1:0]            wr_en;
  logic [NSLOT-1:0]            mask_base;
  logic [NSLOT-1:0]            mask_nxt;
  logic                        complete;
  logic                        overwrite;

  assign slots_flat = slots_q;

  // clear acts before the landing write. Because of that, a write on the clear
  // edge cannot flag an overwrite or complete a set, and the mask is left with
  // only the landed bit set.
  always_comb begin
    wr_en     = s3_valid ? s3_en : '0;
    mask_base = clear ? '0 : slot_valid;
    mask_nxt  = mask_base | wr_en;
    complete  = s3_valid && (&mask_nxt);
    overwrite = s3_valid && !clear && slot_valid[s3_idx];
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      slots_q     <= '0;
      slot_valid  <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      ovr_err     <= 1'b0;
    end else begin
      for (int k = 0; k < NSLOT; k++) begin
        if (wr_en[k]) begin
          slots_q[k] <= s3_data;
        end
      end
      // A completed set empties the mask. The data stays in place so that
      // the set can still be read.
      slot_valid  <= complete ? '0 : mask_nxt;
      frame_done  <= complete;
      frame_count <= complete ? frame_count + CNTW'(1) : frame_count;
      ovr_err     <= clear ? 1'b0 : (ovr_err | overwrite);
    end
  end

endmodule

// File: tb/tb_demux64_scatter.sv
module tb_demux64_scatter;

  localparam int W  = 32;
  localparam int NS = 64;
  localparam int CW = 8;

  logic             clock = 1'b0;
  logic             aclr;
  logic             in_valid;
  logic [W-1:0]     datax;
  logic [5:0]       sel;
  logic             clear;
  logic [NS*W-1:0]  slots_flat;
  logic [NS-1:0]    slot_valid;
  logic             frame_done;
  logic [CW-1:0]    frame_count;
  logic             ovr_err;

  int n_vec = 0;
  int n_err = 0;

  demux64_scatter #(.WIDTH(W), .NSLOT(NS), .CNTW(CW)) dut (
    .clock       (clock),
    .aclr        (aclr),
    .in_valid    (in_valid),
    .datax       (datax),
    .sel         (sel),
    .clear       (clear),
    .slots_flat  (slots_flat),
    .slot_valid  (slot_valid),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .ovr_err     (ovr_err)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  // Accepted words wait in a 3-deep delay line. The word accepted three edges
  // ago is the one that lands on the current edge.
  typedef struct packed {
    logic         v;
    logic [W-1:0] d;
    logic [5:0]   s;
  } acc_t;

  acc_t          pipe_q[$];
  logic [W-1:0]  m_slot [NS];
  logic [NS-1:0] m_valid;
  logic          m_done;
  logic [CW-1:0] m_count;
  logic          m_ovr;

  function automatic logic [NS*W-1:0] m_flat();
    logic [NS*W-1:0] f;
    for (int k = 0; k < NS; k++) f[k*W +: W] = m_slot[k];
    return f;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NS; k++) m_slot[k] = '0;
    m_valid = '0;
    m_done  = 1'b0;
    m_count = '0;
    m_ovr   = 1'b0;
    pipe_q.delete();
    repeat (3) pipe_q.push_back('0);
  endtask

  task automatic model_edge(input logic v, input logic [W-1:0] d, input logic [5:0] s, input logic clr);
    acc_t land;
    acc_t cur;
    land = pipe_q.pop_front();
    cur.v = v;
    cur.d = d;
    cur.s = s;
    pipe_q.push_back(cur);
    m_done = 1'b0;
    if (clr) begin
      m_valid = '0;
      m_ovr   = 1'b0;
    end
    if (land.v) begin
      if (m_valid[land.s]) m_ovr = 1'b1;
      m_slot[land.s]  = land.d;
      m_valid[land.s] = 1'b1;
      if (m_valid == {NS{1'b1}}) begin
        m_valid = '0;
        m_done  = 1'b1;
        m_count = m_count + 1'b1;
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    aclr     = 1'b1;
    in_valid = 1'b0;
    clear    = 1'b0;
    datax    = '0;
    sel      = '0;
    model_reset();
    #2;
    aclr = 1'b0;
  endtask

  task automatic cycle(input logic v, input logic [W-1:0] d, input logic [5:0] s, input logic clr);
    in_valid = v;
    datax    = d;
    sel      = s;
    clear    = clr;
    @(posedge clock);
    #1;
    model_edge(v, d, s, clr);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_vec++;
    if (slot_valid !== '0 || frame_done !== 1'b0 || frame_count !== '0 || ovr_err !== 1'b0 || slots_flat !== '0) begin
      n_err++;
      $display("FAIL reset: valid=%h done=%b cnt=%0d ovr=%b flat_zero=%b, required all 0",
               slot_valid, frame_done, frame_count, ovr_err, slots_flat == '0);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, '0, '0, 1'b0);
      n_vec++;
      if (slot_valid !== '0 || frame_done !== 1'b0 || frame_count !== '0 || ovr_err !== 1'b0 || slots_flat !== '0) begin
        n_err++;
        $display("FAIL idle[%0d]: valid=%h done=%b cnt=%0d ovr=%b, required all 0",
                 i, slot_valid, frame_done, frame_count, ovr_err);
      end
    end
  endtask

  task automatic test_latency();
    logic [NS-1:0] bit37;
    bit37 = '0;
    bit37[37] = 1'b1;
    do_reset();
    cycle(1'b1, 32'hDEADBEEF, 6'd37, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      cycle(1'b0, '0, '0, 1'b0);
      n_vec++;
      if (i < 3 && (slot_valid !== '0 || slots_flat !== '0)) begin
        n_err++;
        $display("FAIL latency_early t+%0d: valid=%h, required 0", i, slot_valid);
      end else if (i == 3 && (slot_valid !== bit37 || slots_flat[37*W +: W] !== 32'hDEADBEEF
                              || slots_flat !== m_flat())) begin
        n_err++;
        $display("FAIL latency_land: valid=%h slot37=%h, required valid=%h slot37=deadbeef",
                 slot_valid, slots_flat[37*W +: W], bit37);
      end
    end
  endtask

  task automatic test_full_set();
    int pulses;
    pulses = 0;
    do_reset();
    for (int i = 0; i < 64; i++) begin
      cycle(1'b1, 32'h100 + W'(i), 6'(i), 1'b0);
      if (frame_done) pulses++;
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, '0, 1'b0);
      if (frame_done) pulses++;
    end
    n_vec++;
    if (frame_done !== 1'b1) begin
      n_err++;
      $display("FAIL full_done_pulse: done=%b, required 1", frame_done);
    end
    cycle(1'b0, '0, '0, 1'b0);
    n_vec++;
    if (pulses !== 1 || frame_done !== 1'b0 || frame_count !== 8'd1 || slot_valid !== '0
        || slots_flat[63*W +: W] !== 32'h13F || ovr_err !== 1'b0 || slots_flat !== m_flat()) begin
      n_err++;
      $display("FAIL full_set: pulses=%0d done=%b cnt=%0d valid=%h slot63=%h ovr=%b, required 1/0/1/0/13f/0",
               pulses, frame_done, frame_count, slot_valid, slots_flat[63*W +: W], ovr_err);
    end
  endtask

  task automatic test_overwrite();
    do_reset();
    cycle(1'b1, 32'd1, 6'd5, 1'b0);
    cycle(1'b1, 32'd2, 6'd5, 1'b0);
    repeat (4) cycle(1'b0, '0, '0, 1'b0);
    n_vec++;
    if (slots_flat[5*W +: W] !== 32'd2 || ovr_err !== 1'b1) begin
      n_err++;
      $display("FAIL overwrite: slot5=%0d ovr=%b, required 2/1", slots_flat[5*W +: W], ovr_err);
    end
    repeat (3) cycle(1'b0, '0, '0, 1'b0);
    n_vec++;
    if (ovr_err !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_sticky: ovr=%b, required 1", ovr_err);
    end
    cycle(1'b0, '0, '0, 1'b1);
    n_vec++;
    if (ovr_err !== 1'b0 || slot_valid !== '0 || slots_flat[5*W +: W] !== 32'd2) begin
      n_err++;
      $display("FAIL clear: ovr=%b valid=%h slot5=%0d, required 0/0/2", ovr_err, slot_valid, slots_flat[5*W +: W]);
    end
  endtask

  task automatic test_clear_collision();
    logic [NS-1:0] bit9;
    bit9 = '0;
    bit9[9] = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, $urandom, 6'(i), 1'b0);
    cycle(1'b1, 32'h0909_0909, 6'd9, 1'b0);
    cycle(1'b0, '0, '0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0);
    n_vec++;
    if (slot_valid !== 64'h0F) begin
      n_err++;
      $display("FAIL collision_pre: valid=%h, required f", slot_valid);
    end
    cycle(1'b0, '0, '0, 1'b1);
    n_vec++;
    if (slot_valid !== bit9 || ovr_err !== 1'b0 || slots_flat[9*W +: W] !== 32'h0909_0909) begin
      n_err++;
      $display("FAIL collision: valid=%h ovr=%b slot9=%h, required %h/0/09090909",
               slot_valid, ovr_err, slots_flat[9*W +: W], bit9);
    end
  endtask

  task automatic test_random();
    logic          v, clr;
    logic [5:0]    s;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(3, 0) != 0);
      s   = (i < 200) ? 6'($urandom_range(7, 0)) : 6'($urandom_range(63, 0));
      clr = ($urandom_range(15, 0) == 0);
      cycle(v, $urandom, s, clr);
      n_vec++;
      if (slot_valid !== m_valid || frame_done !== m_done || frame_count !== m_count
          || ovr_err !== m_ovr || slots_flat !== m_flat()) begin
        n_err++;
        $display("FAIL random[%0d]: valid=%h/%h done=%b/%b cnt=%0d/%0d ovr=%b/%b flat_ok=%b (actual/required)",
                 i, slot_valid, m_valid, frame_done, m_done, frame_count, m_count,
                 ovr_err, m_ovr, slots_flat == m_flat());
      end
    end
  endtask

  task automatic test_wrap_and_midreset();
    int pulses;
    int perm [64];
    int j, t;
    int bad;
    pulses = 0;
    bad    = 0;
    do_reset();
    for (int f = 0; f < 256; f++) begin
      for (int i = 0; i < 64; i++) perm[i] = i;
      for (int i = 63; i > 0; i--) begin
        j = $urandom_range(i, 0);
        t = perm[i];
        perm[i] = perm[j];
        perm[j] = t;
      end
      for (int i = 0; i < 64; i++) begin
        cycle(1'b1, $urandom, 6'(perm[i]), 1'b0);
        if (frame_done) pulses++;
        if (slot_valid !== m_valid || frame_done !== m_done || frame_count !== m_count || ovr_err !== m_ovr)
          bad++;
      end
    end
    repeat (4) begin
      cycle(1'b0, '0, '0, 1'b0);
      if (frame_done) pulses++;
    end
    n_vec++;
    if (bad != 0 || pulses !== 256 || frame_count !== 8'd0 || ovr_err !== 1'b0 || slots_flat !== m_flat()) begin
      n_err++;
      $display("FAIL wrap: cycle_diffs=%0d pulses=%0d cnt=%0d ovr=%b, required 0/256/0/0",
               bad, pulses, frame_count, ovr_err);
    end
    // Words accepted just before a reset must never land.
    cycle(1'b1, 32'hAAAA_0001, 6'd1, 1'b0);
    cycle(1'b1, 32'hAAAA_0002, 6'd2, 1'b0);
    cycle(1'b1, 32'hAAAA_0003, 6'd3, 1'b0);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, '0, '0, 1'b0);
      n_vec++;
      if (slot_valid !== '0 || frame_done !== 1'b0 || frame_count !== '0 || ovr_err !== 1'b0 || slots_flat !== '0) begin
        n_err++;
        $display("FAIL midreset[%0d]: valid=%h done=%b cnt=%0d ovr=%b, required all 0",
                 i, slot_valid, frame_done, frame_count, ovr_err);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_latency();
    test_full_set();
    test_overwrite();
    test_clear_collision();
    test_random();
    test_wrap_and_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
